aes_round_ctrl: RTL and testbench
=================================

Name: aes_round_ctrl

Overview:
- Iterative AES encryption round sequencer.
- Drives the enable and select lines of the shared one-round datapath (SubBytes, ShiftRows, MixColumns, AddRoundKey) and its 128-bit state register through NR rounds per block.
- Requests round keys by index and stalls when the key source is not ready.
- Exposes valid/ready handshakes toward the block source and the ciphertext sink.

Parameters:
NR, 10, number of AES rounds; legal values 10, 12, 14 (AES-128/192/256).
RW, 4, width of round index; must satisfy 2^RW > NR.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  plaintext block presented on datapath input.
in_ready  output  1  controller accepts block this cycle.
key_valid  input  1  round key for current round_idx is available.
round_idx  output  RW  index of round key requested/applied.
init_sel  output  1  datapath loads din XOR key[0] into state register (initial AddRoundKey).
last_round  output  1  datapath bypasses MixColumns this cycle.
state_en  output  1  state register load enable.
out_valid  output  1  state register holds finished ciphertext.
out_ready  input  1  sink accepts ciphertext.
busy  output  1  controller not in IDLE.

Behaviour:
- FSM states: IDLE, ROUND, DONE. Registered state: fsm, round_idx, out_valid.
- Reset values (rst high at an edge): fsm=IDLE, round_idx=0, out_valid=0.
  - Combinational outputs then evaluate to in_ready=key_valid, state_en=0, init_sel=0, last_round=0, busy=0.
- IDLE:
  - round_idx=0.
  - in_ready = key_valid.
  - Accept = in_valid & in_ready.
  - On accept: state_en=1, init_sel=1 in the same cycle; next fsm=ROUND, round_idx=1.
  - in_valid without key_valid: no accept, nothing changes.
- ROUND:
  - in_ready=0.
  - state_en = key_valid.
  - last_round = (round_idx==NR) & key_valid.
  - key_valid=1:
    - round_idx < NR: round_idx increments.
    - round_idx == NR: next fsm=DONE, out_valid set, round_idx held at NR.
  - key_valid=0: stall; round_idx, fsm and state register hold; state_en=0.
- DONE:
  - out_valid=1, state_en=0, in_ready=0.
  - State register and round_idx held until out_valid & out_ready.
  - Then next fsm=IDLE, round_idx=0, out_valid=0.
  - No back-to-back accept in the handoff cycle; a new block is accepted from the following IDLE cycle.
- busy = (fsm != IDLE).
- Latency with key_valid held high:
  - Accept at cycle T.
  - Rounds 1..NR at cycles T+1..T+NR.
  - out_valid high from cycle T+NR+1.
  - Minimum block interval NR+2 cycles, when out_ready is high at T+NR+1.
- init_sel and last_round are never both high. state_en is high on exactly NR+1 cycles per block.
- Outputs depend combinationally only on fsm, round_idx and key_valid/in_valid. There is no combinational path from out_ready to any output except through registers.
- rst mid-block (ROUND or DONE): next cycle is IDLE with round_idx=0 and out_valid=0. The partial result is discarded, and no out_valid pulse is produced for it.
- in_valid dropping while in ROUND/DONE is ignored; the block is already captured.
- in_valid and out_ready high simultaneously in DONE: only the output handshake completes.

Test Plan:
- Reset then idle, NR=10, key_valid=1, in_valid=0 -> in_ready=1, busy=0, round_idx=0, state_en=0, out_valid=0 for 5 cycles.
- Single block, key_valid=1, out_ready=1, accept at cycle 0:
  - init_sel=1 at cycle 0.
  - round_idx 1..10 on cycles 1..10; last_round=1 only at cycle 10.
  - state_en high on exactly 11 cycles.
  - out_valid=1 at cycle 11, IDLE at cycle 12.
- Key stall: key_valid=0 for 3 cycles while round_idx=4 -> round_idx stays 4, state_en=0 for 3 cycles; out_valid delayed to cycle 14.
- Output backpressure: out_ready=0 for 5 cycles after completion -> out_valid, round_idx=10 and busy held; in_ready=0 throughout; IDLE one cycle after out_ready rises.
- Reset mid-op: rst pulsed while round_idx=6 -> next cycle fsm=IDLE, round_idx=0, out_valid never asserts; a new block is then accepted normally.
- NR=14 build with two back-to-back blocks, out_ready=1 -> second accept exactly 16 cycles after the first; last_round only at round_idx=14.

Source files
------------

// File: rtl/aes_round_ctrl.sv
// Iterative AES encryption round sequencer: steps the shared one-round datapath
// through NR rounds per block, with stalls on the key source and on the ciphertext sink.
module aes_round_ctrl #(
   parameter int unsigned NR = 10,
   parameter int unsigned RW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          key_valid,
   output logic [RW-1:0] round_idx,
   output logic          init_sel,
   output logic          last_round,
   output logic          state_en,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          busy
);

   typedef enum logic [1:0] {
      IDLE,
      ROUND,
      DONE
   } fsm_e;

   localparam logic [RW-1:0] LAST_IDX = RW'(NR);

   fsm_e          fsm_q, fsm_d;
   logic [RW-1:0] round_idx_q, round_idx_d;
   logic          out_valid_q, out_valid_d;
   logic          accept;

   assign accept = (fsm_q == IDLE) & in_valid & key_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_q       <= IDLE;
         round_idx_q <= '0;
         out_valid_q <= 1'b0;
      end else begin
         fsm_q       <= fsm_d;
         round_idx_q <= round_idx_d;
         out_valid_q <= out_valid_d;
      end
   end

   always_comb begin
      fsm_d       = fsm_q;
      round_idx_d = round_idx_q;
      out_valid_d = out_valid_q;
      case (fsm_q)
         IDLE: begin
            if (accept) begin
               fsm_d       = ROUND;
               round_idx_d = RW'(1);
            end
         end
         ROUND: begin
            // The final round holds its index so the sink sees round_idx == NR while in DONE.
            if (key_valid) begin
               if (round_idx_q == LAST_IDX) begin
                  fsm_d       = DONE;
                  out_valid_d = 1'b1;
               end else begin
                  round_idx_d = round_idx_q + RW'(1);
               end
            end
         end
         DONE: begin
            if (out_ready) begin
               fsm_d       = IDLE;
               round_idx_d = '0;
               out_valid_d = 1'b0;
            end
         end
         default: begin
            fsm_d       = IDLE;
            round_idx_d = '0;
            out_valid_d = 1'b0;
         end
      endcase
   end

   always_comb begin
      in_ready   = 1'b0;
      init_sel   = 1'b0;
      last_round = 1'b0;
      state_en   = 1'b0;
      case (fsm_q)
         IDLE: begin
            in_ready = key_valid;
            init_sel = accept;
            state_en = accept;
         end
         ROUND: begin
            state_en   = key_valid;
            last_round = (round_idx_q == LAST_IDX) & key_valid;
         end
         default: ;
      endcase
   end

   assign busy      = (fsm_q != IDLE);
   assign round_idx = round_idx_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl: NR=10 and NR=14 instances share stimulus and are
// compared every cycle against a block-phase model, plus hand-computed timing checks.
module tb_aes_round_ctrl;

   localparam int NR0 = 10;
   localparam int NR1 = 14;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst       = 1'b1;
   logic in_valid  = 1'b0;
   logic key_valid = 1'b1;
   logic out_ready = 1'b1;

   logic [1:0] in_ready, init_sel, last_round, state_en, out_valid, busy;
   logic [3:0] ri0, ri1;

   int  n_vec  = 0;
   int  n_err  = 0;
   bit  chk_en = 1'b0;
   // Model phase per instance: 0 = idle, 1..NR = waiting to apply round k, NR+1 = result held.
   int  ph [2] = '{0, 0};

   aes_round_ctrl #(.NR(NR0), .RW(4)) dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
      .key_valid(key_valid), .round_idx(ri0), .init_sel(init_sel[0]),
      .last_round(last_round[0]), .state_en(state_en[0]), .out_valid(out_valid[0]),
      .out_ready(out_ready), .busy(busy[0])
   );

   aes_round_ctrl #(.NR(NR1), .RW(4)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
      .key_valid(key_valid), .round_idx(ri1), .init_sel(init_sel[1]),
      .last_round(last_round[1]), .state_en(state_en[1]), .out_valid(out_valid[1]),
      .out_ready(out_ready), .busy(busy[1])
   );

   function automatic int nr_of(input int i);
      return (i == 0) ? NR0 : NR1;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rst) ph[i] = 0;
         else if (ph[i] == 0) begin
            if (in_valid && key_valid) ph[i] = 1;
         end else if (ph[i] <= nr_of(i)) begin
            if (key_valid) ph[i] = ph[i] + 1;
         end else if (out_ready) ph[i] = 0;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 2; i++) begin
            int n, idx, e_idx;
            bit idle, done, rnd;
            n     = nr_of(i);
            idle  = (ph[i] == 0);
            done  = (ph[i] == n + 1);
            rnd   = !idle && !done;
            idx   = (i == 0) ? int'(ri0) : int'(ri1);
            e_idx = idle ? 0 : (done ? n : ph[i]);
            check($sformatf("in_ready[%0d]", i), int'(in_ready[i]), int'(idle && key_valid));
            check($sformatf("init_sel[%0d]", i), int'(init_sel[i]), int'(idle && in_valid && key_valid));
            check($sformatf("state_en[%0d]", i), int'(state_en[i]),
                  int'((idle && in_valid && key_valid) || (rnd && key_valid)));
            check($sformatf("last_round[%0d]", i), int'(last_round[i]), int'(rnd && ph[i] == n && key_valid));
            check($sformatf("round_idx[%0d]", i), idx, e_idx);
            check($sformatf("out_valid[%0d]", i), int'(out_valid[i]), int'(done));
            check($sformatf("busy[%0d]", i), int'(busy[i]), int'(!idle));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      in_valid  = 1'b0;
      key_valid = 1'b1;
      out_ready = 1'b1;
      #1;
      while (busy != 2'b00 && k < 60) begin
         step();
         k++;
      end
      check("idle_timeout", int'(busy == 2'b00), 1);
      step();
   endtask

   initial begin
      int se_cnt;
      int a0 [2];
      int a1 [2];
      int n0, n1;

      // Reset, then idle with key_valid high.
      step();
      step();
      chk_en = 1'b1;
      check("rst_out_valid", int'(out_valid[0]), 0);
      check("rst_busy", int'(busy[0]), 0);
      check("rst_round_idx", int'(ri0), 0);
      check("rst_in_ready", int'(in_ready[0]), 1);
      rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         step();
         check("idle_in_ready", int'(in_ready[0]), 1);
         check("idle_busy", int'(busy[0]), 0);
         check("idle_state_en", int'(state_en[0]), 0);
         check("idle_out_valid", int'(out_valid[0]), 0);
      end

      // Single block: accept at cycle 0, rounds 1..10, ciphertext at 11, idle at 12.
      step();
      in_valid = 1'b1;
      #1;
      check("blk_init_sel", int'(init_sel[0]), 1);
      se_cnt = int'(state_en[0]);
      for (int c = 1; c <= 12; c++) begin
         step();
         in_valid = 1'b0;
         #1;
         se_cnt += int'(state_en[0]);
         if (c <= 10) begin
            check("blk_round_idx", int'(ri0), c);
            check("blk_last_round", int'(last_round[0]), int'(c == 10));
            check("blk_init_low", int'(init_sel[0]), 0);
         end
         if (c == 11) check("blk_out_valid", int'(out_valid[0]), 1);
         if (c == 12) check("blk_idle", int'(busy[0]), 0);
      end
      check("blk_state_en_count", se_cnt, 11);
      wait_idle();

      // Key stall at round 4 for three cycles delays the result to cycle 14.
      step();
      in_valid = 1'b1;
      #1;
      for (int c = 1; c <= 14; c++) begin
         step();
         in_valid  = 1'b0;
         key_valid = !(c >= 4 && c <= 6);
         #1;
         if (c >= 4 && c <= 6) begin
            check("stall_round_idx", int'(ri0), 4);
            check("stall_state_en", int'(state_en[0]), 0);
         end
         check("stall_out_valid", int'(out_valid[0]), int'(c == 14));
      end
      wait_idle();

      // Output backpressure for five cycles; in_valid is asserted throughout DONE.
      step();
      in_valid  = 1'b1;
      out_ready = 1'b0;
      #1;
      for (int c = 1; c <= 17; c++) begin
         step();
         in_valid  = (c >= 11 && c <= 16);
         out_ready = (c >= 16);
         #1;
         if (c >= 11 && c <= 16) begin
            check("bp_out_valid", int'(out_valid[0]), 1);
            check("bp_round_idx", int'(ri0), 10);
            check("bp_busy", int'(busy[0]), 1);
            check("bp_in_ready", int'(in_ready[0]), 0);
         end
         if (c == 17) begin
            check("bp_release_busy", int'(busy[0]), 0);
            check("bp_release_out_valid", int'(out_valid[0]), 0);
         end
      end
      wait_idle();

      // Reset pulse while round_idx is 6 discards the block.
      step();
      in_valid = 1'b1;
      #1;
      for (int c = 1; c <= 6; c++) begin
         step();
         in_valid = 1'b0;
         #1;
      end
      check("rm_round_idx_before", int'(ri0), 6);
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      check("rm_busy", int'(busy[0]), 0);
      check("rm_round_idx", int'(ri0), 0);
      check("rm_busy14", int'(busy[1]), 0);
      for (int c = 0; c < 20; c++) begin
         step();
         check("rm_no_out_valid", int'(out_valid != 2'b00), 0);
      end
      step();
      in_valid = 1'b1;
      #1;
      check("rm_new_accept", int'(init_sel[0]), 1);
      for (int c = 1; c <= 11; c++) begin
         step();
         in_valid = 1'b0;
         #1;
      end
      check("rm_new_out_valid", int'(out_valid[0]), 1);
      wait_idle();

      // Back-to-back blocks: accept interval NR+2 on both instances.
      n0 = 0;
      n1 = 0;
      a0 = '{-100, -100};
      a1 = '{-100, -100};
      for (int c = 0; c < 40; c++) begin
         step();
         in_valid = 1'b1;
         #1;
         if (init_sel[0] && n0 < 2) begin a0[n0] = c; n0++; end
         if (init_sel[1] && n1 < 2) begin a1[n1] = c; n1++; end
         if (last_round[1]) check("b2b_last_round_idx14", int'(ri1), 14);
      end
      check("b2b_accepts14", n1, 2);
      check("b2b_interval14", a1[1] - a1[0], 16);
      check("b2b_interval10", a0[1] - a0[0], 12);
      wait_idle();

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
